// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC operand bank: copy FSM states, default slot roles
// and the address-width helper.
package ecc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } cp_state_e;

    localparam int SLOT_QX   = 0;
    localparam int SLOT_QY   = 1;
    localparam int SLOT_KR   = 2;
    localparam int SLOT_DS   = 3;
    localparam int SLOT_HASH = 4;
    localparam int SLOT_D    = 5;

    // Index width for n entries; a single entry still needs one address bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ecc_opnd_bank_if.sv
// Host and engine side signals of the operand bank; the bank is the slave, the
// SPI command decoder / ECC engines together form the master.
interface ecc_opnd_bank_if
    import ecc_pkg::*;
#(
    parameter int DW    = 32,
    parameter int NWORD = 8,
    parameter int NSLOT = 6
);
    localparam int SW  = clog2_min1(NSLOT);
    localparam int WW  = clog2_min1(NWORD);
    localparam int OPW = DW * NWORD;

    logic                   clr;
    logic                   wr_en;
    logic [SW+WW-1:0]       wr_addr;
    logic [DW-1:0]          wr_d;
    logic                   wr_err;
    logic                   rd_en;
    logic [SW+WW-1:0]       rd_addr;
    logic [DW-1:0]          rd_d;
    logic                   rd_vld;
    logic                   ld_en;
    logic [SW-1:0]          ld_slot;
    logic [OPW-1:0]         ld_d;
    logic                   cp_start;
    logic [SW-1:0]          cp_src;
    logic [SW-1:0]          cp_dst;
    logic                   cp_busy;
    logic                   cp_done;
    logic [NSLOT*OPW-1:0]   opnd;
    logic [NSLOT-1:0]       zero_flg;

    modport master (
        output clr, wr_en, wr_addr, wr_d, rd_en, rd_addr, ld_en, ld_slot, ld_d,
               cp_start, cp_src, cp_dst,
        input  wr_err, rd_d, rd_vld, cp_busy, cp_done, opnd, zero_flg
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_d, rd_en, rd_addr, ld_en, ld_slot, ld_d,
               cp_start, cp_src, cp_dst,
        output wr_err, rd_d, rd_vld, cp_busy, cp_done, opnd, zero_flg
    );

endinterface

// File: rtl/ecc_opnd_copy_fsm.sv
// Slot-to-slot copy sequencer: latches src/dst, walks one word per cycle and
// raises the word-write strobe while copying.
module ecc_opnd_copy_fsm
    import ecc_pkg::*;
#(
    parameter int NSLOT = 6,
    parameter int NWORD = 8,
    parameter int SW    = clog2_min1(NSLOT),
    parameter int WW    = clog2_min1(NWORD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          abort_i,
    input  logic          start_i,
    input  logic [SW-1:0] src_i,
    input  logic [SW-1:0] dst_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          we_o,
    output logic [SW-1:0] src_o,
    output logic [SW-1:0] dst_o,
    output logic [WW-1:0] cnt_o
);
    cp_state_e     state_q;
    logic          busy_q;
    logic          done_q;
    logic [SW-1:0] src_q;
    logic [SW-1:0] dst_q;
    logic [WW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
        end else if (abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && int'(src_i) < NSLOT && int'(dst_i) < NSLOT) begin
                        state_q <= ST_COPY;
                        busy_q  <= 1'b1;
                        done_q  <= (NWORD == 1);
                        src_q   <= src_i;
                        dst_q   <= dst_i;
                        cnt_q   <= '0;
                    end
                end
                ST_COPY: begin
                    if (int'(cnt_q) == NWORD - 1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q + WW'(1);
                        // done is registered, so it is raised as the counter reaches the last word
                        done_q <= (int'(cnt_q) == NWORD - 2);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign we_o   = (state_q == ST_COPY);
    assign src_o  = src_q;
    assign dst_o  = dst_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/ecc_opnd_bank.sv
// Operand register bank: NSLOT operands of NWORD x DW bits with host word access,
// engine bulk load, slot copy, masked clear and per-slot zero flags.
module ecc_opnd_bank
    import ecc_pkg::*;
#(
    parameter int               DW       = 32,
    parameter int               NWORD    = 8,
    parameter int               NSLOT    = 6,
    parameter logic [NSLOT-1:0] CLR_MASK = 6'h1F
) (
    input  logic            clk,
    input  logic            rst,
    ecc_opnd_bank_if.slave  bus
);
    localparam int SW   = clog2_min1(NSLOT);
    localparam int WW   = clog2_min1(NWORD);
    localparam int OPW  = DW * NWORD;
    localparam int NENT = NSLOT * NWORD;

    logic [DW-1:0] mem_q [NENT];
    logic [DW-1:0] mem_d [NENT];

    logic [SW-1:0] wr_slot, rd_slot;
    logic [WW-1:0] wr_word, rd_word;
    logic          wr_ok, rd_ok, ld_ok, host_we, cp_wr;
    int            wr_idx, rd_idx, cp_src_idx, cp_dst_idx;
    logic [DW-1:0] rd_data, cp_rdata;
    logic [DW-1:0] rd_d_q;
    logic          rd_vld_q, wr_err_q;

    logic          cp_we;
    logic [SW-1:0] cp_src_q, cp_dst_q;
    logic [WW-1:0] cp_cnt;

    ecc_opnd_copy_fsm #(
        .NSLOT (NSLOT),
        .NWORD (NWORD),
        .SW    (SW),
        .WW    (WW)
    ) u_copy (
        .clk     (clk),
        .rst     (rst),
        .abort_i (bus.clr),
        .start_i (bus.cp_start),
        .src_i   (bus.cp_src),
        .dst_i   (bus.cp_dst),
        .busy_o  (bus.cp_busy),
        .done_o  (bus.cp_done),
        .we_o    (cp_we),
        .src_o   (cp_src_q),
        .dst_o   (cp_dst_q),
        .cnt_o   (cp_cnt)
    );

    assign {wr_slot, wr_word} = bus.wr_addr;
    assign {rd_slot, rd_word} = bus.rd_addr;
    assign wr_ok      = (int'(wr_slot) < NSLOT) && (int'(wr_word) < NWORD);
    assign rd_ok      = (int'(rd_slot) < NSLOT) && (int'(rd_word) < NWORD);
    assign wr_idx     = int'(wr_slot) * NWORD + int'(wr_word);
    assign rd_idx     = int'(rd_slot) * NWORD + int'(rd_word);
    assign cp_src_idx = int'(cp_src_q) * NWORD + int'(cp_cnt);
    assign cp_dst_idx = int'(cp_dst_q) * NWORD + int'(cp_cnt);

    // Only one writer owns the storage each cycle: clr, then load, then copy, then host.
    assign ld_ok   = bus.ld_en && (int'(bus.ld_slot) < NSLOT) && !bus.clr;
    assign cp_wr   = cp_we && !bus.clr && !ld_ok;
    assign host_we = bus.wr_en && wr_ok && !bus.cp_busy && !bus.clr && !ld_ok;

    always_comb begin
        rd_data  = '0;
        cp_rdata = '0;
        for (int i = 0; i < NENT; i++) begin
            if (i == rd_idx)     rd_data  = mem_q[i];
            if (i == cp_src_idx) cp_rdata = mem_q[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NENT; gi++) begin : g_ent
            localparam int S = gi / NWORD;
            localparam int W = gi % NWORD;
            assign mem_d[gi] = (bus.clr && CLR_MASK[S])               ? '0 :
                               (ld_ok && int'(bus.ld_slot) == S)      ? bus.ld_d[OPW-1-W*DW -: DW] :
                               (cp_wr && cp_dst_idx == gi)            ? cp_rdata :
                               (host_we && wr_idx == gi)              ? bus.wr_d :
                                                                        mem_q[gi];
            // word 0 is the most significant word of its operand
            assign bus.opnd[S*OPW + (NWORD-1-W)*DW +: DW] = mem_q[gi];
        end
        for (gi = 0; gi < NSLOT; gi++) begin : g_zero
            assign bus.zero_flg[gi] = ~|bus.opnd[gi*OPW +: OPW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d_q   <= '0;
            rd_vld_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            rd_vld_q <= bus.rd_en;
            wr_err_q <= bus.wr_en && !host_we;
            if (bus.rd_en) rd_d_q <= rd_ok ? rd_data : '0;
        end
    end

    assign bus.rd_d   = rd_d_q;
    assign bus.rd_vld = rd_vld_q;
    assign bus.wr_err = wr_err_q;

endmodule
